// File: rtl/fifo_wr_arbiter_if.sv
// Handshake and FIFO write-port bundle for fifo_wr_arbiter.
// master = arbiter side, slave = producers plus FIFO side.
interface fifo_wr_arbiter_if #(
  parameter int DATA_W  = 128,
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
);
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_ready;
  logic                      o_full;
  logic                      o_alm_full;
  logic                      i_wren;
  logic [DATA_W-1:0]         i_wrdata;
  logic [ID_W-1:0]           gnt_id;
  logic                      busy;

  modport master (
    input  req_valid, req_data, o_full, o_alm_full,
    output req_ready, i_wren, i_wrdata, gnt_id, busy
  );

  modport slave (
    output req_valid, req_data, o_full, o_alm_full,
    input  req_ready, i_wren, i_wrdata, gnt_id, busy
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ valid/ready
// requesters, with bursts of up to BURST_LEN beats and full/almost-full backpressure.
module fifo_wr_arbiter #(
  parameter int DATA_W    = 128,
  parameter int NUM_REQ   = 4,
  parameter int BURST_LEN = 8,
  parameter int ID_W      = $clog2(NUM_REQ)
) (
  input  logic              clk,
  input  logic              rstn,
  fifo_wr_arbiter_if.master bus
);

  localparam int CNT_W = $clog2(BURST_LEN + 1);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_GRANT = 1'b1
  } state_t;

  state_t           r_state,    w_state_nxt;
  logic [ID_W-1:0]  r_gnt_id,   w_gnt_id_nxt;
  logic [ID_W-1:0]  r_rr_ptr,   w_rr_ptr_nxt;
  logic [CNT_W-1:0] r_beat_cnt, w_beat_cnt_nxt;

  logic [ID_W-1:0]  w_pick_id;
  logic [ID_W-1:0]  w_idx;
  logic [ID_W-1:0]  w_gnt_inc;
  logic             w_any_valid;
  logic             w_cur_valid;
  logic             w_beat;
  logic             w_last_beat;
  logic             w_release;

  // Search rr_ptr, rr_ptr+1, ... and keep the first valid requester found.
  // NOTE: every signal written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    w_pick_id   = r_rr_ptr;
    w_any_valid = 1'b0;
    w_idx       = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_idx = ID_W'((int'(r_rr_ptr) + i) % NUM_REQ);
      if (!w_any_valid && bus.req_valid[w_idx]) begin
        w_any_valid = 1'b1;
        w_pick_id   = w_idx;
      end
    end
  end

  assign w_cur_valid = bus.req_valid[r_gnt_id];
  assign w_beat      = (r_state == S_GRANT) && w_cur_valid && !bus.o_full;
  assign w_last_beat = (r_beat_cnt == CNT_W'(BURST_LEN - 1));
  assign w_gnt_inc   = (r_gnt_id == ID_W'(NUM_REQ - 1)) ? '0 : r_gnt_id + ID_W'(1);

  // Burst ends on the last permitted beat, on a beat taken while almost full,
  // or when the owner withdraws; a full FIFO just freezes the burst.
  assign w_release = (w_beat && (w_last_beat || bus.o_alm_full)) || !w_cur_valid;

  always_comb begin
    w_state_nxt    = r_state;
    w_gnt_id_nxt   = r_gnt_id;
    w_rr_ptr_nxt   = r_rr_ptr;
    w_beat_cnt_nxt = r_beat_cnt;
    case (r_state)
      S_IDLE: begin
        if (w_any_valid) begin
          w_state_nxt    = S_GRANT;
          w_gnt_id_nxt   = w_pick_id;
          w_beat_cnt_nxt = '0;
        end
      end
      S_GRANT: begin
        if (w_release) begin
          w_state_nxt    = S_IDLE;
          w_rr_ptr_nxt   = w_gnt_inc;
          w_beat_cnt_nxt = '0;
        end else if (w_beat) begin
          w_beat_cnt_nxt = r_beat_cnt + CNT_W'(1);
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of block ordering in simulation.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state    <= S_IDLE;
      r_gnt_id   <= '0;
      r_rr_ptr   <= '0;
      r_beat_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_gnt_id   <= w_gnt_id_nxt;
      r_rr_ptr   <= w_rr_ptr_nxt;
      r_beat_cnt <= w_beat_cnt_nxt;
    end
  end

  // Zero-latency write: the handshake cycle is the FIFO write cycle.
  always_comb begin
    bus.req_ready           = '0;
    bus.req_ready[r_gnt_id] = w_beat;
  end

  assign bus.i_wren   = w_beat;
  assign bus.i_wrdata = (r_state == S_GRANT) ? bus.req_data[int'(r_gnt_id)*DATA_W +: DATA_W] : '0;
  assign bus.gnt_id   = r_gnt_id;
  assign bus.busy     = (r_state == S_GRANT);

endmodule
